reduce_arbiter_seq: RTL and testbench
=====================================

// Module: reduce_arbiter_seq
// PURPOSE
//  Bit-serial reduction engine that shares one 2-input LUT gate between two requesters.
//  Each job reduces a WIDTH-bit word with AND, OR or XOR, one operand bit per clock.
//  A round-robin arbiter picks the requester; an FSM sequences the bit walk.
//  Sits between icestick I/O logic (J1 headers, D LEDs) and the shared reduce datapath.
//  Replaces per-requester WIDTH-LUT reduce chains.
// PARAMETERS
//  WIDTH   8   operand width in bits; legal range 2..32
// PORTS
//  CLK     in   1      sole clock; rising edge
//  RESET   in   1      asynchronous, active-high reset
//  REQ0    in   1      requester 0 job request; held until GNT0 is seen
//  I0      in   WIDTH  requester 0 operand; stable while REQ0 is high
//  OP0     in   2      requester 0 op: 00 AND, 01 OR, 10 XOR, 11 reserved (executes as AND)
//  GNT0    out  1      requester 0 grant; operand sampled on the edge where GNT0=1
//  REQ1    in   1      requester 1 job request
//  I1      in   WIDTH  requester 1 operand
//  OP1     in   2      requester 1 op (same encoding as OP0)
//  GNT1    out  1      requester 1 grant
//  BUSY    out  1      high in RUN and DONE states
//  VALID   out  1      one-cycle pulse; O and ID are valid
//  O       out  1      reduction result; holds until the next VALID
//  ID      out  1      requester index of the result in O; holds with O
// BEHAVIOUR
//  Reset values: state IDLE, GNT0/1=0, BUSY=0, VALID=0, O=0, ID=0, cnt=0, acc=0.
//  RR pointer resets to favour requester 0.
//  RESET mid-job aborts the job immediately; no VALID is produced.
//  A requester whose REQ is still high after reset is re-arbitrated.
//  FSM states:
//   IDLE: GNTx combinational (Mealy).
//    Only one REQ high -> grant that requester.
//    Both REQ high -> grant the requester not granted last; the pointer then flips.
//    On the grant edge: latch operand and op; acc <= identity (AND 1, OR 0, XOR 0);
//    cnt <= 0; go to RUN.
//   RUN: each cycle acc <= acc op opnd[cnt]; cnt <= cnt+1.
//    After bit WIDTH-1 is consumed, go to DONE. GNT0/1 stay 0.
//   DONE: VALID=1, O=acc, ID=granted index, all for this one cycle; go to IDLE.
//    Grants are never issued in DONE.
//  Latency: grant edge = cycle 0; RUN occupies cycles 1..WIDTH; VALID in cycle WIDTH+1.
//   The next grant is possible at cycle WIDTH+2.
//  REQ asserted during RUN/DONE waits; no request is lost or reordered.
//  Only GNT is a handshake; the result path has no back-pressure.
//  Operand and op changes after the grant edge have no effect on the running job.
//  cnt is clog2(WIDTH) bits wide and never wraps within a job; it is reset on each grant.
// CONFIGURATION
//  REDUCE_EARLY_EXIT_EN defined:
//   - In RUN, if op=AND and the new acc=0, or op=OR and the new acc=1,
//     go to DONE on the next cycle (remaining bits skipped).
//   - XOR always runs the full WIDTH cycles.
//   - O and ID values are identical to the non-early-exit build; only the latency shrinks.
//  REDUCE_EARLY_EXIT_EN undefined:
//   - Every job takes exactly WIDTH RUN cycles; latency is fixed at WIDTH+1.
// TESTING (WIDTH=8)
//  1. REQ0=1, I0=8'hFF, OP0=00 -> GNT0 pulse; VALID at grant+9, O=1, ID=0.
//  2. REQ1=1, I1=8'h80, OP1=10 -> VALID at grant+9, O=1, ID=1.
//     Same job with I1=8'h81 -> O=0.
//  3. REQ0 and REQ1 both high from reset, both held:
//     grants in order 0,1,0,1; VALIDs 10 cycles apart; ID alternates 0,1,0,1.
//  4. I0=8'hFE, OP0=00:
//     EARLY_EXIT build -> VALID at grant+2, O=0.
//     Plain build -> VALID at grant+9, O=0.
//  5. RESET at grant+4 of an OR job -> GNT0/1, BUSY, VALID, O, ID all 0 next sample.
//     No VALID for the aborted job.
//     Held REQ0 is re-granted after RESET drops.
//  6. OP0=11, I0=8'h7F -> treated as AND: O=0.
//     Toggling I0 during RUN does not change O.

Source files
------------

// File: rtl/reduce_arbiter_seq.sv
// Bit-serial AND/OR/XOR reduction shared by two round-robin requesters.
// Optional macro REDUCE_EARLY_EXIT_EN: end AND/OR jobs as soon as the result is decided.
module reduce_arbiter_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] I0,
  input  logic [1:0]       OP0,
  output logic             GNT0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] I1,
  input  logic [1:0]       OP1,
  output logic             GNT1,
  output logic             BUSY,
  output logic             VALID,
  output logic             O,
  output logic             ID
);

  // state | meaning
  // IDLE  | arbitrate; Mealy grant and operand capture
  // RUN   | consume one operand bit per cycle
  // DONE  | one-cycle VALID with O/ID
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic             last_gnt;
  logic [WIDTH-1:0] opnd;
  logic [1:0]       op;
  logic [CW-1:0]    cnt;
  logic             acc, acc_nxt;
  logic             o_reg, id_reg, gid;
  logic             bit_cur, last_bit, stop_early;
  logic [1:0]       op_sel;
  logic             sel_is_and;

  assign bit_cur  = opnd[cnt];
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    case (op)
      2'b01:   acc_nxt = acc | bit_cur;
      2'b10:   acc_nxt = acc ^ bit_cur;
      default: acc_nxt = acc & bit_cur;
    endcase
  end

`ifdef REDUCE_EARLY_EXIT_EN
  // AND reaching 0 or OR reaching 1 can never change again
  assign stop_early = ((op == 2'b00 || op == 2'b11) && !acc_nxt) ||
                      (op == 2'b01 && acc_nxt);
`else
  assign stop_early = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    GNT0      = 1'b0;
    GNT1      = 1'b0;
    case (state)
      IDLE: begin
        if (!RESET) begin
          // last_gnt=1 means requester 1 went last, so 0 wins a tie
          if (REQ0 && (!REQ1 || last_gnt)) GNT0 = 1'b1;
          else if (REQ1)                   GNT1 = 1'b1;
        end
        if (GNT0 || GNT1) state_nxt = RUN;
      end
      RUN:     if (last_bit || stop_early) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign op_sel     = GNT1 ? OP1 : OP0;
  assign sel_is_and = !(op_sel == 2'b01 || op_sel == 2'b10);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_gnt <= 1'b1;
      opnd     <= '0;
      op       <= 2'b00;
      cnt      <= '0;
      acc      <= 1'b0;
      gid      <= 1'b0;
      o_reg    <= 1'b0;
      id_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (GNT0 || GNT1) begin
            opnd     <= GNT1 ? I1 : I0;
            op       <= op_sel;
            acc      <= sel_is_and;
            cnt      <= '0;
            gid      <= GNT1;
            last_gnt <= GNT1;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (!last_bit) cnt <= cnt + CW'(1);
          if (last_bit || stop_early) begin
            o_reg  <= acc_nxt;
            id_reg <= gid;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY  = (state == RUN) || (state == DONE);
  assign VALID = (state == DONE);
  assign O     = o_reg;
  assign ID    = id_reg;

endmodule

// File: tb/tb_reduce_arbiter_seq.sv
// Directed plus randomized bench for reduce_arbiter_seq against a word-level reduction model.
module tb_reduce_arbiter_seq;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         REQ0, REQ1;
  logic [W-1:0] I0, I1;
  logic [1:0]   OP0, OP1;
  logic         GNT0, GNT1, BUSY, VALID, O, ID;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  reduce_arbiter_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .I0(I0), .OP0(OP0), .GNT0(GNT0),
    .REQ1(REQ1), .I1(I1), .OP1(OP1), .GNT1(GNT1),
    .BUSY(BUSY), .VALID(VALID), .O(O), .ID(ID)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic ref_o(input logic [W-1:0] d, input logic [1:0] op);
    case (op)
      2'b01:   return |d;
      2'b10:   return ^d;
      default: return &d;
    endcase
  endfunction

  // cycles from the grant cycle to the VALID cycle
  function automatic int ref_lat(input logic [W-1:0] d, input logic [1:0] op);
`ifdef REDUCE_EARLY_EXIT_EN
    for (int i = 0; i < W; i++) begin
      if (op != 2'b01 && op != 2'b10 && !d[i]) return i + 2;
      if (op == 2'b01 && d[i]) return i + 2;
    end
`endif
    return W + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_gnt(input int idx, input string tag);
    int n = 0;
    while (((idx == 0) ? GNT0 : GNT1) !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_gnt"}, (idx == 0) ? GNT0 : GNT1, 1);
    chk({tag, "_gnt_other"}, (idx == 0) ? GNT1 : GNT0, 0);
  endtask

  task automatic run_job(input int idx, input logic [W-1:0] d, input logic [1:0] op,
                         input bit scramble, input string tag);
    int lat;
    logic exp_o;
    exp_o = ref_o(d, op);
    if (idx == 0) begin REQ0 = 1'b1; I0 = d; OP0 = op; end
    else          begin REQ1 = 1'b1; I1 = d; OP1 = op; end
    #1;
    wait_gnt(idx, tag);
    tick();
    if (idx == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
    chk({tag, "_busy"}, BUSY, 1);
    lat = 1;
    while (VALID !== 1'b1 && lat < 50) begin
      if (scramble) begin
        if (idx == 0) begin I0 = W'($urandom); OP0 = 2'($urandom); end
        else          begin I1 = W'($urandom); OP1 = 2'($urandom); end
      end
      tick();
      lat++;
    end
    chk({tag, "_valid"}, VALID, 1);
    chk({tag, "_latency"}, lat, ref_lat(d, op));
    chk({tag, "_o"}, O, exp_o);
    chk({tag, "_id"}, ID, idx);
    tick();
    chk({tag, "_valid_pulse"}, VALID, 0);
    chk({tag, "_o_hold"}, O, exp_o);
    chk({tag, "_id_hold"}, ID, idx);
  endtask

  initial begin
    int   prev_vt, lat, n;
    logic last, exp_id;
    logic [W-1:0] d;

    RESET = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    I0 = '0; I1 = '0; OP0 = 2'b00; OP1 = 2'b00;
    repeat (3) tick();
    chk("rst_gnt0", GNT0, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_o", O, 0);
    chk("rst_id", ID, 0);
    RESET = 1'b0;
    tick();

    run_job(0, 8'hFF, 2'b00, 0, "t1_and_ff");
    run_job(1, 8'h80, 2'b10, 0, "t2_xor_80");
    run_job(1, 8'h81, 2'b10, 0, "t2_xor_81");
    run_job(0, 8'hFE, 2'b00, 0, "t4_and_fe");
    run_job(1, 8'h00, 2'b01, 0, "t4_or_00");
    run_job(0, 8'h7F, 2'b11, 0, "t6_rsv_7f");
    run_job(0, 8'hFF, 2'b11, 1, "t6_rsv_ff_scramble");
    run_job(1, 8'h01, 2'b01, 0, "pre5_or_01");

    // abort an OR job four cycles after its grant
    REQ0 = 1'b1; I0 = 8'h00; OP0 = 2'b01;
    #1;
    wait_gnt(0, "t5");
    repeat (4) tick();
    chk("t5_busy_before", BUSY, 1);
    RESET = 1'b1;
    #1;
    chk("t5_gnt0", GNT0, 0);
    chk("t5_gnt1", GNT1, 0);
    chk("t5_busy", BUSY, 0);
    chk("t5_valid", VALID, 0);
    chk("t5_o", O, 0);
    chk("t5_id", ID, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t5_no_valid", VALID, 0);
    end
    RESET = 1'b0;
    #1;
    chk("t5_regrant", GNT0, 1);
    run_job(0, 8'h10, 2'b01, 0, "t5_after");

    // both requesters held from reset
    RESET = 1'b1;
    REQ0 = 1'b1; REQ1 = 1'b1;
    I0 = 8'hFF; OP0 = 2'b00;
    I1 = 8'h01; OP1 = 2'b10;
    repeat (2) tick();
    RESET = 1'b0;
    #1;
    last = 1'b1;
    prev_vt = 0;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (!(GNT0 || GNT1) && n < 50) begin tick(); n++; end
      exp_id = ~last;
      last = exp_id;
      chk("t3_gnt_one", GNT0 ^ GNT1, 1);
      chk("t3_gnt_order", GNT1, exp_id);
      lat = 0;
      tick();
      lat++;
      while (VALID !== 1'b1 && lat < 50) begin tick(); lat++; end
      chk("t3_valid", VALID, 1);
      chk("t3_id", ID, exp_id);
      chk("t3_o", O, 1);
      if (j > 0) chk("t3_spacing", cyc - prev_vt, 10);
      prev_vt = cyc;
      tick();
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (12) tick();

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0:       d = 8'hFF;
        1:       d = 8'h00;
        default: d = W'($urandom);
      endcase
      run_job(int'($urandom_range(0, 1)), d, 2'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)), "rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
